key_tone_gen: RTL and testbench

Tone-generator stage directly downstream of the PS/2 key decoder. Consumes the 18-bit one-hot key bus (bit 0 = A … bit 17 = ') and produces a signed 24-bit square-wave audio sample stream for the audio codec interface. Each accepted sample advances the oscillator and the attack/release envelope. The block synchronises the key bus, selects one note, and paces output through a valid/ready handshake.

---
 rtl/key_tone_gen.sv | 202 ++++++++++++++++++++
 tb/tb_key_tone_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_tone_gen.sv
// Key-tone generator: one-hot key bus to a signed 24-bit square wave paced by valid/ready.
// Define KEY_TONE_ENVELOPE_EN for attack/release ramps; otherwise notes gate straight on/off.
module key_tone_gen #(
    parameter int unsigned SAMPLE_HZ    = 48000,
    parameter int unsigned AMP_MAX      = 4194303,
    parameter int unsigned ATTACK_STEP  = 4096,
    parameter int unsigned RELEASE_STEP = 2048
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [17:0] key_bus,
    input  logic        sample_ready,
    output logic        sample_valid,
    output logic [23:0] sample_data,
    output logic        note_on,
    output logic [4:0]  active_note
);

    typedef enum logic [1:0] {S_IDLE, S_ATTACK, S_SUSTAIN, S_RELEASE} state_t;

    // Note frequencies in mHz (C4 = 261.63 Hz, equal temperament); rounded half-period in samples.
    function automatic int unsigned hp_calc(input int n);
        int unsigned f_mhz;
        case (n)
            0:       f_mhz = 261630;
            1:       f_mhz = 277183;
            2:       f_mhz = 293666;
            3:       f_mhz = 311132;
            4:       f_mhz = 329629;
            5:       f_mhz = 349234;
            6:       f_mhz = 370004;
            7:       f_mhz = 392002;
            8:       f_mhz = 415312;
            9:       f_mhz = 440007;
            10:      f_mhz = 466171;
            11:      f_mhz = 493892;
            12:      f_mhz = 523260;
            13:      f_mhz = 554375;
            14:      f_mhz = 587331;
            15:      f_mhz = 622264;
            16:      f_mhz = 659258;
            17:      f_mhz = 698468;
            default: f_mhz = 261630;
        endcase
        return (SAMPLE_HZ * 1000 + f_mhz) / (2 * f_mhz);
    endfunction

    logic [15:0] w_hp_tab [32];
    for (genvar g = 0; g < 32; g++) begin : g_hp
        assign w_hp_tab[g] = 16'(hp_calc(g));
    end

    logic [17:0] r_sync1, r_sync2, r_prev, r_stable;
    state_t      r_state;
    logic [4:0]  r_note;
    logic [15:0] r_phase;
    logic        r_level;
    logic [22:0] r_amp;
    logic        r_valid;
    logic [23:0] r_data;

    logic [17:0] w_stable_n;
    logic        w_key;
    logic [4:0]  w_sel;
    logic [15:0] w_hp;
    logic        w_load;
    logic [23:0] w_amp_up;
    logic [23:0] w_mag;
    logic [23:0] w_sample;
    state_t      w_state_n;
    logic [4:0]  w_note_n;
    logic [15:0] w_phase_n;
    logic        w_level_n;
    logic [22:0] w_amp_n;

    assign w_stable_n = (r_sync2 == r_prev) ? r_sync2 : r_stable;
    assign w_key      = |w_stable_n;
    assign w_hp       = w_hp_tab[r_note];
    // A slot is refilled whenever it is empty; oscillator and envelope advance once per sample issued.
    assign w_load     = !r_valid;
    assign w_amp_up   = {1'b0, r_amp} + 24'(ATTACK_STEP);
    assign w_mag      = {1'b0, r_amp};
    assign w_sample   = (r_state == S_IDLE) ? '0 : (r_level ? w_mag : -w_mag);

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 18; i > 0; i--) begin
            if (w_stable_n[5'(i - 1)]) w_sel = 5'(i - 1);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_note_n  = r_note;
        w_phase_n = r_phase;
        w_level_n = r_level;
        w_amp_n   = r_amp;

        if (w_load && (r_state != S_IDLE)) begin
            if (r_phase == w_hp - 16'd1) begin
                w_phase_n = '0;
                w_level_n = ~r_level;
            end else begin
                w_phase_n = r_phase + 16'd1;
            end
            if (r_state == S_ATTACK) begin
                if (w_amp_up >= 24'(AMP_MAX)) begin
                    w_amp_n   = 23'(AMP_MAX);
                    w_state_n = S_SUSTAIN;
                end else begin
                    w_amp_n = w_amp_up[22:0];
                end
            end else if (r_state == S_RELEASE) begin
                if (r_amp <= 23'(RELEASE_STEP)) begin
                    w_amp_n   = '0;
                    w_state_n = S_IDLE;
                    w_phase_n = '0;
                    w_level_n = 1'b1;
                end else begin
                    w_amp_n = r_amp - 23'(RELEASE_STEP);
                end
            end
        end

        // Key events override the per-sample advance so the next sample starts the new note cleanly.
        case (r_state)
            S_IDLE: begin
                if (w_key) begin
                    w_note_n  = w_sel;
                    w_phase_n = '0;
                    w_level_n = 1'b1;
`ifdef KEY_TONE_ENVELOPE_EN
                    w_state_n = S_ATTACK;
                    w_amp_n   = '0;
`else
                    w_state_n = S_SUSTAIN;
                    w_amp_n   = 23'(AMP_MAX);
`endif
                end
            end
            S_ATTACK, S_SUSTAIN: begin
                if (!w_key) begin
`ifdef KEY_TONE_ENVELOPE_EN
                    w_state_n = S_RELEASE;
`else
                    w_state_n = S_IDLE;
                    w_amp_n   = '0;
                    w_phase_n = '0;
                    w_level_n = 1'b1;
`endif
                end else if (w_sel != r_note) begin
                    w_note_n  = w_sel;
                    w_phase_n = '0;
                    w_level_n = 1'b1;
                end
            end
            S_RELEASE: begin
                if (w_key) begin
                    w_state_n = S_ATTACK;
                    w_note_n  = w_sel;
                    w_phase_n = '0;
                    w_level_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_stable <= '0;
            r_state  <= S_IDLE;
            r_note   <= '0;
            r_phase  <= '0;
            r_level  <= 1'b1;
            r_amp    <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            r_sync1  <= key_bus;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_stable <= w_stable_n;
            r_state  <= w_state_n;
            r_note   <= w_note_n;
            r_phase  <= w_phase_n;
            r_level  <= w_level_n;
            r_amp    <= w_amp_n;
            r_valid  <= r_valid ? !sample_ready : 1'b1;
            if (w_load) r_data <= w_sample;
        end
    end

    assign sample_valid = r_valid;
    assign sample_data  = r_data;
    assign note_on      = (r_state != S_IDLE);
    assign active_note  = r_note;

endmodule

// File: tb/tb_key_tone_gen.sv
// Directed bench for key_tone_gen; expectations follow the build's KEY_TONE_ENVELOPE_EN setting.
module tb_key_tone_gen;

    localparam int MAX = 4194303;

    logic        clk = 1'b0;
    logic        resetn;
    logic [17:0] key_bus;
    logic        sample_ready;
    logic        sample_valid;
    logic [23:0] sample_data;
    logic        note_on;
    logic [4:0]  active_note;

    int n_checks = 0;
    int n_pass   = 0;

    key_tone_gen #(
        .SAMPLE_HZ   (48000),
        .AMP_MAX     (4194303),
        .ATTACK_STEP (4096),
        .RELEASE_STEP(2048)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .key_bus     (key_bus),
        .sample_ready(sample_ready),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .note_on     (note_on),
        .active_note (active_note)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] sq(input int a, input bit lvl);
        return lvl ? 24'(a) : 24'(-a);
    endfunction

    // Waits (bounded) for the next offered sample and returns it; with ready high it is accepted next edge.
    task automatic get_sample(output logic [23:0] d);
        int t;
        t = 0;
        @(negedge clk);
        while (sample_valid !== 1'b1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (sample_valid !== 1'b1) begin
            n_checks++;
            $display("FAIL sample_timeout valid=%b required 1", sample_valid);
        end
        d = sample_data;
    endtask

    // Releases any key, waits for IDLE, presses k and returns the first nonzero sample of the new note.
    task automatic start_note(input logic [17:0] k, output logic [23:0] d);
        int t;
        key_bus = '0;
        t = 0;
        while (note_on !== 1'b0 && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (note_on !== 1'b0) begin
            n_checks++;
            $display("FAIL idle_timeout note_on=%b required 0", note_on);
        end
        key_bus = k;
        d = '0;
        t = 0;
        while (d == 24'd0 && t < 20) begin
            get_sample(d);
            t++;
        end
        if (d == 24'd0) begin
            n_checks++;
            $display("FAIL tone_timeout data=0 required nonzero");
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; sample_ready = 1'b1; key_bus = '0;
        repeat (4) @(negedge clk);
        n_checks++; if (sample_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", sample_valid); else n_pass++;
        n_checks++; if (sample_data !== 24'd0) $display("FAIL rst_data got %0d want 0", sample_data); else n_pass++;
        n_checks++; if (note_on !== 1'b0) $display("FAIL rst_note_on got %b want 0", note_on); else n_pass++;
        n_checks++; if (active_note !== 5'd0) $display("FAIL rst_active_note got %0d want 0", active_note); else n_pass++;
        resetn = 1'b1;
        #1;
        n_checks++; if (sample_valid !== 1'b0) $display("FAIL rst_cycle1_valid got %b want 0", sample_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (sample_valid !== 1'b1) $display("FAIL rst_cycle2_valid got %b want 1", sample_valid); else n_pass++;
        n_checks++; if (sample_data !== 24'd0) $display("FAIL rst_cycle2_data got %0d want 0", sample_data); else n_pass++;
    endtask

    task automatic test_key_latency;
        key_bus = 18'h00001;
        repeat (3) @(negedge clk);
        n_checks++; if (note_on !== 1'b0) $display("FAIL lat3_note_on got %b want 0", note_on); else n_pass++;
        @(negedge clk);
        n_checks++; if (note_on !== 1'b1) $display("FAIL lat4_note_on got %b want 1", note_on); else n_pass++;
        n_checks++; if (active_note !== 5'd0) $display("FAIL lat4_note got %0d want 0", active_note); else n_pass++;
    endtask

    task automatic test_multihot_glitch;
        int bad;
        key_bus = 18'h00030;
        repeat (5) @(negedge clk);
        n_checks++; if (active_note !== 5'd4) $display("FAIL multihot_note got %0d want 4", active_note); else n_pass++;
        n_checks++; if (note_on !== 1'b1) $display("FAIL multihot_note_on got %b want 1", note_on); else n_pass++;
        key_bus = 18'h00100;
        @(negedge clk);
        key_bus = 18'h00030;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (active_note !== 5'd4 || note_on !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL glitch_cycles_wrong got %0d want 0", bad); else n_pass++;
        key_bus = 18'h20020;
        repeat (5) @(negedge clk);
        n_checks++; if (active_note !== 5'd5) $display("FAIL lowest_bit_note got %0d want 5", active_note); else n_pass++;
        key_bus = 18'h20000;
        repeat (5) @(negedge clk);
        n_checks++; if (active_note !== 5'd17) $display("FAIL top_key_note got %0d want 17", active_note); else n_pass++;
    endtask

`ifdef KEY_TONE_ENVELOPE_EN
    function automatic int mag(input logic [23:0] d);
        logic signed [23:0] s;
        s = d;
        return (s < 0) ? -int'(s) : int'(s);
    endfunction

    task automatic test_attack_release;
        logic [23:0] d;
        logic [23:0] d1023, d1024, d1100, dj2047, dj2048;
        int bad, amp, t;
        start_note(18'h01000, d);
        n_checks++; if (d !== 24'd4096) $display("FAIL attack_k1 got %0d want 4096", $signed(d)); else n_pass++;
        bad = 0; d1023 = '0; d1024 = '0; d1100 = '0;
        for (int k = 2; k <= 1100; k++) begin
            get_sample(d);
            amp = (k * 4096 > MAX) ? MAX : k * 4096;
            if (d !== sq(amp, ((k / 46) % 2) == 0)) bad++;
            if (k == 1023) d1023 = d;
            if (k == 1024) d1024 = d;
            if (k == 1100) d1100 = d;
        end
        n_checks++; if (bad != 0) $display("FAIL attack_ramp_wrong got %0d want 0", bad); else n_pass++;
        n_checks++; if (d1023 !== 24'd4190208) $display("FAIL attack_k1023 got %0d want 4190208", $signed(d1023)); else n_pass++;
        n_checks++; if (d1024 !== 24'(MAX)) $display("FAIL attack_k1024 got %0d want %0d", $signed(d1024), MAX); else n_pass++;
        n_checks++; if (d1100 !== sq(MAX, 1'b0)) $display("FAIL sustain_k1100 got %0d want %0d", $signed(d1100), -MAX); else n_pass++;
        n_checks++; if (active_note !== 5'd12) $display("FAIL attack_note got %0d want 12", active_note); else n_pass++;
        key_bus = '0;
        t = 0;
        d = 24'(MAX);
        while (mag(d) == MAX && t < 10) begin
            get_sample(d);
            t++;
        end
        n_checks++; if (mag(d) != MAX - 2048) $display("FAIL release_j1 got %0d want %0d", mag(d), MAX - 2048); else n_pass++;
        bad = 0; dj2047 = '0; dj2048 = '1;
        for (int j = 2; j <= 2048; j++) begin
            get_sample(d);
            amp = (j == 2048) ? 0 : MAX - j * 2048;
            if (mag(d) != amp) bad++;
            if (j == 2047) dj2047 = d;
            if (j == 2048) dj2048 = d;
        end
        n_checks++; if (bad != 0) $display("FAIL release_ramp_wrong got %0d want 0", bad); else n_pass++;
        n_checks++; if (mag(dj2047) != 2047) $display("FAIL release_j2047 got %0d want 2047", mag(dj2047)); else n_pass++;
        n_checks++; if (dj2048 !== 24'd0) $display("FAIL release_j2048 got %0d want 0", $signed(dj2048)); else n_pass++;
        n_checks++; if (note_on !== 1'b0) $display("FAIL release_note_on got %b want 0", note_on); else n_pass++;
    endtask

    task automatic test_retrigger;
        logic [23:0] d, d68, d69;
        int t;
        start_note(18'h01000, d);
        t = 0;
        while (mag(d) != MAX && t < 1100) begin
            get_sample(d);
            t++;
        end
        key_bus = '0;
        t = 0;
        while (mag(d) == MAX && t < 10) begin
            get_sample(d);
            t++;
        end
        for (int j = 2; j <= 97; j++) get_sample(d);
        key_bus = 18'h00020;
        get_sample(d);
        get_sample(d);
        n_checks++; if (mag(d) != MAX - 99 * 2048) $display("FAIL retrig_j99 got %0d want %0d", mag(d), MAX - 99 * 2048); else n_pass++;
        get_sample(d);
        n_checks++; if (d !== 24'(MAX - 100 * 2048)) $display("FAIL retrig_k0 got %0d want %0d", $signed(d), MAX - 100 * 2048); else n_pass++;
        get_sample(d);
        n_checks++; if (d !== 24'(MAX - 100 * 2048 + 4096)) $display("FAIL retrig_k1 got %0d want %0d", $signed(d), MAX - 100 * 2048 + 4096); else n_pass++;
        n_checks++; if (active_note !== 5'd5) $display("FAIL retrig_note got %0d want 5", active_note); else n_pass++;
        d68 = '0; d69 = '0;
        for (int k = 2; k <= 69; k++) begin
            get_sample(d);
            if (k == 68) d68 = d;
            if (k == 69) d69 = d;
        end
        n_checks++; if (d68 !== 24'(MAX)) $display("FAIL retrig_k68 got %0d want %0d", $signed(d68), MAX); else n_pass++;
        n_checks++; if (d69 !== sq(MAX, 1'b0)) $display("FAIL retrig_k69 got %0d want %0d", $signed(d69), -MAX); else n_pass++;
    endtask
`else
    task automatic test_tone_pitch;
        logic [23:0] d, d91, d92, d184;
        int bad;
        start_note(18'h00001, d);
        n_checks++; if (d !== 24'(MAX)) $display("FAIL pitch_k0 got %0d want %0d", $signed(d), MAX); else n_pass++;
        bad = 0; d91 = '0; d92 = '0; d184 = '0;
        for (int k = 1; k <= 200; k++) begin
            get_sample(d);
            if (d !== sq(MAX, ((k / 92) % 2) == 0)) bad++;
            if (k == 91) d91 = d;
            if (k == 92) d92 = d;
            if (k == 184) d184 = d;
        end
        n_checks++; if (bad != 0) $display("FAIL pitch_pattern_wrong got %0d want 0", bad); else n_pass++;
        n_checks++; if (d91 !== 24'(MAX)) $display("FAIL pitch_k91 got %0d want %0d", $signed(d91), MAX); else n_pass++;
        n_checks++; if (d92 !== sq(MAX, 1'b0)) $display("FAIL pitch_k92 got %0d want %0d", $signed(d92), -MAX); else n_pass++;
        n_checks++; if (d184 !== 24'(MAX)) $display("FAIL pitch_k184 got %0d want %0d", $signed(d184), MAX); else n_pass++;
        n_checks++; if (active_note !== 5'd0) $display("FAIL pitch_note got %0d want 0", active_note); else n_pass++;
    endtask

    task automatic test_note12_pitch;
        logic [23:0] d, d45, d46;
        int bad;
        start_note(18'h01000, d);
        bad = 0; d45 = '0; d46 = '0;
        for (int k = 1; k <= 92; k++) begin
            get_sample(d);
            if (d !== sq(MAX, ((k / 46) % 2) == 0)) bad++;
            if (k == 45) d45 = d;
            if (k == 46) d46 = d;
        end
        n_checks++; if (bad != 0) $display("FAIL n12_pattern_wrong got %0d want 0", bad); else n_pass++;
        n_checks++; if (d45 !== 24'(MAX)) $display("FAIL n12_k45 got %0d want %0d", $signed(d45), MAX); else n_pass++;
        n_checks++; if (d46 !== sq(MAX, 1'b0)) $display("FAIL n12_k46 got %0d want %0d", $signed(d46), -MAX); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [23:0] d, held, d91, d92;
        int hold_bad, bad;
        start_note(18'h00001, d);
        for (int k = 1; k <= 9; k++) get_sample(d);
        get_sample(held);
        sample_ready = 1'b0;
        hold_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (sample_valid !== 1'b1 || sample_data !== held) hold_bad++;
        end
        sample_ready = 1'b1;
        n_checks++; if (hold_bad != 0) $display("FAIL bp_hold_wrong got %0d want 0", hold_bad); else n_pass++;
        n_checks++; if (held !== 24'(MAX)) $display("FAIL bp_k10 got %0d want %0d", $signed(held), MAX); else n_pass++;
        bad = 0; d91 = '0; d92 = '0;
        for (int k = 11; k <= 95; k++) begin
            get_sample(d);
            if (d !== sq(MAX, ((k / 92) % 2) == 0)) bad++;
            if (k == 91) d91 = d;
            if (k == 92) d92 = d;
        end
        n_checks++; if (bad != 0) $display("FAIL bp_pattern_wrong got %0d want 0", bad); else n_pass++;
        n_checks++; if (d91 !== 24'(MAX)) $display("FAIL bp_k91 got %0d want %0d", $signed(d91), MAX); else n_pass++;
        n_checks++; if (d92 !== sq(MAX, 1'b0)) $display("FAIL bp_k92 got %0d want %0d", $signed(d92), -MAX); else n_pass++;
    endtask

    task automatic test_release;
        logic [23:0] d;
        key_bus = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (note_on !== 1'b1) $display("FAIL rel3_note_on got %b want 1", note_on); else n_pass++;
        @(negedge clk);
        n_checks++; if (note_on !== 1'b0) $display("FAIL rel4_note_on got %b want 0", note_on); else n_pass++;
        get_sample(d);
        n_checks++; if (d !== 24'd0) $display("FAIL rel_idle_data got %0d want 0", $signed(d)); else n_pass++;
    endtask
`endif

    initial begin
        resetn = 1'b0;
        key_bus = '0;
        sample_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_key_latency();
        test_multihot_glitch();
`ifdef KEY_TONE_ENVELOPE_EN
        test_attack_release();
        test_retrigger();
`else
        test_tone_pitch();
        test_note12_pitch();
        test_backpressure();
        test_release();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
